bus_terminal_endpoint: RTL and testbench

BUS_TERMINAL_ENDPOINT -- requirements
Module: bus_terminal_endpoint

---
 rtl/bus_terminal_endpoint.sv | 134 +++++++++++++
 tb/tb_bus_terminal_endpoint.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bus_terminal_endpoint.sv
// Bus terminal endpoint: a TX FIFO feeding the bus controller and an address-filtered RX FIFO
// feeding the host, with saturating event counters for rejected traffic.
module bus_terminal_endpoint #(
   parameter int          PCKG_SZ   = 32,
   parameter int          DEPTH     = 16,
   parameter logic [7:0]  ID        = 8'h00,
   parameter logic [7:0]  BROADCAST = 8'hFF,
   localparam int         AW        = $clog2(DEPTH),
   localparam int         CW        = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   output logic               pndng,
   output logic [PCKG_SZ-1:0] D_pop,
   input  logic               pop,
   input  logic               push,
   input  logic [PCKG_SZ-1:0] D_push,
   input  logic               host_wr,
   input  logic [PCKG_SZ-1:0] host_wdata,
   output logic               host_full,
   input  logic               host_rd,
   output logic [PCKG_SZ-1:0] host_rdata,
   output logic               host_empty,
   output logic [CW-1:0]      tx_count,
   output logic [CW-1:0]      rx_count,
   output logic [7:0]         drop_cnt,
   output logic [7:0]         misroute_cnt,
   output logic [7:0]         underflow_cnt
);

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
      logic [8:0] s;
      s = {1'b0, a} + {7'b0, inc};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   function automatic logic [CW-1:0] next_count(input logic [CW-1:0] c, input logic wr, input logic rd);
      logic [CW-1:0] r;
      case ({wr, rd})
         2'b10:   r = c + CW'(1);
         2'b01:   r = c - CW'(1);
         default: r = c;
      endcase
      return r;
   endfunction

   logic [PCKG_SZ-1:0] tx_mem_q [DEPTH];
   logic [PCKG_SZ-1:0] rx_mem_q [DEPTH];

   logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [7:0]    drop_q, drop_d, mis_q, mis_d, und_q, und_d;

   logic [7:0] tx_dest, rx_dest;
   logic       tx_full, rx_full, tx_nonempty, rx_nonempty;
   logic       tx_pop_ok, tx_self, tx_wr_ok, tx_underflow;
   logic       rx_rd_ok, rx_addr_ok, rx_mis, rx_wr_ok, rx_drop;

   always_comb begin
      tx_dest      = host_wdata[PCKG_SZ-1 -: 8];
      rx_dest      = D_push[PCKG_SZ-1 -: 8];
      tx_full      = (tx_cnt_q == CW'(DEPTH));
      rx_full      = (rx_cnt_q == CW'(DEPTH));
      tx_nonempty  = (tx_cnt_q != '0);
      rx_nonempty  = (rx_cnt_q != '0);

      tx_pop_ok    = pop && tx_nonempty;
      tx_underflow = pop && !tx_nonempty;
      tx_self      = host_wr && (tx_dest == ID);
      // A full FIFO still takes a write when the head leaves in the same cycle.
      tx_wr_ok     = host_wr && !tx_self && (!tx_full || tx_pop_ok);

      rx_rd_ok     = host_rd && rx_nonempty;
      rx_addr_ok   = (rx_dest == ID) || (rx_dest == BROADCAST);
      rx_mis       = push && !rx_addr_ok;
      rx_wr_ok     = push && rx_addr_ok && (!rx_full || rx_rd_ok);
      rx_drop      = push && rx_addr_ok && rx_full && !rx_rd_ok;

      tx_wp_d  = tx_wr_ok  ? tx_wp_q + AW'(1) : tx_wp_q;
      tx_rp_d  = tx_pop_ok ? tx_rp_q + AW'(1) : tx_rp_q;
      rx_wp_d  = rx_wr_ok  ? rx_wp_q + AW'(1) : rx_wp_q;
      rx_rp_d  = rx_rd_ok  ? rx_rp_q + AW'(1) : rx_rp_q;
      tx_cnt_d = next_count(tx_cnt_q, tx_wr_ok, tx_pop_ok);
      rx_cnt_d = next_count(rx_cnt_q, rx_wr_ok, rx_rd_ok);

      // Self-send on TX and misroute on RX in the same cycle both count.
      mis_d    = sat_add(mis_q, {1'b0, tx_self} + {1'b0, rx_mis});
      drop_d   = sat_add(drop_q, {1'b0, rx_drop});
      und_d    = sat_add(und_q, {1'b0, tx_underflow});
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
         drop_q   <= '0;
         mis_q    <= '0;
         und_q    <= '0;
      end else begin
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
         drop_q   <= drop_d;
         mis_q    <= mis_d;
         und_q    <= und_d;
      end
   end

   // Storage carries no reset; stale entries are unreachable once pointers and counts clear.
   always_ff @(posedge clk) begin
      if (reset && tx_wr_ok) tx_mem_q[tx_wp_q] <= host_wdata;
      if (reset && rx_wr_ok) rx_mem_q[rx_wp_q] <= D_push;
   end

   assign pndng         = tx_nonempty;
   assign D_pop         = tx_nonempty ? tx_mem_q[tx_rp_q] : '0;
   assign host_full     = tx_full;
   assign host_empty    = !rx_nonempty;
   assign host_rdata    = rx_nonempty ? rx_mem_q[rx_rp_q] : '0;
   assign tx_count      = tx_cnt_q;
   assign rx_count      = rx_cnt_q;
   assign drop_cnt      = drop_q;
   assign misroute_cnt  = mis_q;
   assign underflow_cnt = und_q;

endmodule

// File: tb/tb_bus_terminal_endpoint.sv
// Bench for bus_terminal_endpoint (ID=3, DEPTH=16): vector table plus queue scoreboard for FIFO data.
module tb_bus_terminal_endpoint;

   logic        clk = 1'b0;
   logic        reset;
   logic        pndng;
   logic [31:0] D_pop;
   logic        pop;
   logic        push;
   logic [31:0] D_push;
   logic        host_wr;
   logic [31:0] host_wdata;
   logic        host_full;
   logic        host_rd;
   logic [31:0] host_rdata;
   logic        host_empty;
   logic [4:0]  tx_count;
   logic [4:0]  rx_count;
   logic [7:0]  drop_cnt;
   logic [7:0]  misroute_cnt;
   logic [7:0]  underflow_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] tx_q[$];
   logic [31:0] rx_q[$];

   always #5 clk = ~clk;

   bus_terminal_endpoint #(
      .PCKG_SZ(32), .DEPTH(16), .ID(8'h03), .BROADCAST(8'hFF)
   ) dut (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
      .D_push(D_push), .host_wr(host_wr), .host_wdata(host_wdata), .host_full(host_full),
      .host_rd(host_rd), .host_rdata(host_rdata), .host_empty(host_empty),
      .tx_count(tx_count), .rx_count(rx_count), .drop_cnt(drop_cnt),
      .misroute_cnt(misroute_cnt), .underflow_cnt(underflow_cnt)
   );

   typedef struct {
      logic        wr;
      logic [31:0] wdata;
      logic        pop;
      logic        push;
      logic [31:0] dpush;
      logic        rd;
      logic [4:0]  e_tx;
      logic [4:0]  e_rx;
      logic        e_pndng;
      logic [31:0] e_dpop;
      logic [31:0] e_rdata;
      logic [7:0]  e_mis;
      logic [7:0]  e_und;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Drives one cycle; the scoreboard checks departing heads and records arriving words.
   task automatic cycle(input logic wr, input logic [31:0] wd, input logic p,
                        input logic ps, input logic [31:0] dp, input logic rd);
      int txs, rxs;
      logic tpop, rpop;
      logic [31:0] e;
      host_wr = wr; host_wdata = wd; pop = p; push = ps; D_push = dp; host_rd = rd;
      txs = tx_q.size();
      rxs = rx_q.size();
      tpop = p && (txs > 0);
      if (tpop) begin
         e = tx_q.pop_front();
         chk("sb_d_pop", D_pop, e);
      end
      if (wr && (wd[31:24] != 8'h03) && ((txs < 16) || tpop)) tx_q.push_back(wd);
      rpop = rd && (rxs > 0);
      if (rpop) begin
         e = rx_q.pop_front();
         chk("sb_host_rdata", host_rdata, e);
      end
      if (ps && ((dp[31:24] == 8'h03) || (dp[31:24] == 8'hFF)) && ((rxs < 16) || rpop))
         rx_q.push_back(dp);
      @(posedge clk);
      #1;
      host_wr = 1'b0; pop = 1'b0; push = 1'b0; host_rd = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'h05AABBCC, 1'b0, 1'b0, 32'h0,        1'b0, 5'd1, 5'd0, 1'b1, 32'h05AABBCC, 32'h0,        8'd0, 8'd0};
      vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b0, 32'h0,        32'h0,        8'd0, 8'd0};
      vecs[2]  = '{1'b1, 32'h03123456, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b0, 32'h0,        32'h0,        8'd1, 8'd0};
      vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h03000001, 1'b0, 5'd0, 5'd1, 1'b0, 32'h0,        32'h03000001, 8'd1, 8'd0};
      vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hFF000002, 1'b0, 5'd0, 5'd2, 1'b0, 32'h0,        32'h03000001, 8'd1, 8'd0};
      vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h07000003, 1'b0, 5'd0, 5'd2, 1'b0, 32'h0,        32'h03000001, 8'd2, 8'd0};
      vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 5'd0, 5'd1, 1'b0, 32'h0,        32'hFF000002, 8'd2, 8'd0};
      vecs[7]  = '{1'b1, 32'h03000020, 1'b0, 1'b1, 32'h09000000, 1'b0, 5'd0, 5'd1, 1'b0, 32'h0,        32'hFF000002, 8'd4, 8'd0};
      vecs[8]  = '{1'b1, 32'h01000011, 1'b0, 1'b1, 32'hFF000004, 1'b1, 5'd1, 5'd1, 1'b1, 32'h01000011, 32'hFF000004, 8'd4, 8'd0};
      vecs[9]  = '{1'b1, 32'h02000012, 1'b1, 1'b0, 32'h0,        1'b1, 5'd1, 5'd0, 1'b1, 32'h02000012, 32'h0,        8'd4, 8'd0};
      vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b0, 32'h0,        32'h0,        8'd4, 8'd0};
      vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 5'd0, 5'd0, 1'b0, 32'h0,        32'h0,        8'd4, 8'd0};
      vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b0, 32'h0,        32'h0,        8'd4, 8'd1};

      reset = 1'b0;
      host_wr = 1'b0; host_wdata = '0; pop = 1'b0; push = 1'b0; D_push = '0; host_rd = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pndng",      32'(pndng),         32'd0);
      chk("rst_d_pop",      D_pop,              32'd0);
      chk("rst_host_full",  32'(host_full),     32'd0);
      chk("rst_host_empty", 32'(host_empty),    32'd1);
      chk("rst_host_rdata", host_rdata,         32'd0);
      chk("rst_tx_count",   32'(tx_count),      32'd0);
      chk("rst_rx_count",   32'(rx_count),      32'd0);
      chk("rst_counters",   {8'h0, drop_cnt, misroute_cnt, underflow_cnt}, 32'd0);
      reset = 1'b1;

      for (int i = 0; i < 13; i++) begin
         cycle(vecs[i].wr, vecs[i].wdata, vecs[i].pop, vecs[i].push, vecs[i].dpush, vecs[i].rd);
         chk($sformatf("v%0d_tx_count", i),   32'(tx_count),      32'(vecs[i].e_tx));
         chk($sformatf("v%0d_rx_count", i),   32'(rx_count),      32'(vecs[i].e_rx));
         chk($sformatf("v%0d_pndng", i),      32'(pndng),         32'(vecs[i].e_pndng));
         chk($sformatf("v%0d_d_pop", i),      D_pop,              vecs[i].e_dpop);
         chk($sformatf("v%0d_host_rdata", i), host_rdata,         vecs[i].e_rdata);
         chk($sformatf("v%0d_host_empty", i), 32'(host_empty),    32'(vecs[i].e_rx == 5'd0));
         chk($sformatf("v%0d_misroute", i),   32'(misroute_cnt),  32'(vecs[i].e_mis));
         chk($sformatf("v%0d_underflow", i),  32'(underflow_cnt), 32'(vecs[i].e_und));
      end
      chk("tbl_drop_cnt", 32'(drop_cnt), 32'd0);

      // TX fill to full, write while full, write-with-pop while full, then drain in order.
      for (int i = 0; i < 16; i++) cycle(1'b1, 32'h01000100 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
      chk("txfull_host_full", 32'(host_full), 32'd1);
      chk("txfull_count",     32'(tx_count),  32'd16);
      cycle(1'b1, 32'h010000FF, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("txfull_ignored_count", 32'(tx_count), 32'd16);
      cycle(1'b1, 32'h010000EE, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("txfull_wr_pop_count", 32'(tx_count), 32'd16);
      chk("txfull_wr_pop_head",  D_pop,         32'h01000101);
      for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("txdrain_pndng", 32'(pndng), 32'd0);
      chk("txdrain_sb_empty", 32'(tx_q.size()), 32'd0);

      // RX fill to full, drop on full, accepted when read in same cycle, then drain.
      for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h03000100 + 32'(i), 1'b0);
      chk("rxfull_count", 32'(rx_count), 32'd16);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h03000009, 1'b0);
      chk("rxfull_drop_cnt", 32'(drop_cnt), 32'd1);
      chk("rxfull_drop_count", 32'(rx_count), 32'd16);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h03000009, 1'b1);
      chk("rxfull_rd_drop_cnt", 32'(drop_cnt), 32'd1);
      chk("rxfull_rd_count",    32'(rx_count), 32'd16);
      for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("rxdrain_empty", 32'(host_empty), 32'd1);
      chk("rxdrain_sb_empty", 32'(rx_q.size()), 32'd0);
      chk("rxdrain_misroute", 32'(misroute_cnt), 32'd4);

      // Underflow saturation.
      for (int i = 0; i < 300; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("underflow_sat", 32'(underflow_cnt), 32'hFF);
      chk("underflow_tx_count", 32'(tx_count), 32'd0);

      // Reset mid-operation with traffic presented during reset.
      for (int i = 0; i < 8; i++) cycle(1'b1, 32'h02000200 + 32'(i), 1'b0, 1'b1, 32'hFF000300 + 32'(i), 1'b0);
      chk("prerst_tx_count", 32'(tx_count), 32'd8);
      chk("prerst_rx_count", 32'(rx_count), 32'd8);
      reset = 1'b0;
      host_wr = 1'b1; host_wdata = 32'h02000AAA; push = 1'b1; D_push = 32'h03000BBB;
      pop = 1'b1; host_rd = 1'b1;
      @(posedge clk);
      #1;
      host_wr = 1'b0; push = 1'b0; pop = 1'b0; host_rd = 1'b0;
      tx_q.delete();
      rx_q.delete();
      reset = 1'b1;
      chk("midrst_pndng",      32'(pndng),      32'd0);
      chk("midrst_d_pop",      D_pop,           32'd0);
      chk("midrst_host_empty", 32'(host_empty), 32'd1);
      chk("midrst_host_rdata", host_rdata,      32'd0);
      chk("midrst_counts",     {22'h0, tx_count, rx_count}, 32'd0);
      chk("midrst_counters",   {8'h0, drop_cnt, misroute_cnt, underflow_cnt}, 32'd0);
      cycle(1'b1, 32'h0400ABCD, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("postrst_tx_count", 32'(tx_count), 32'd1);
      chk("postrst_d_pop",    D_pop,         32'h0400ABCD);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("postrst_pndng", 32'(pndng), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
